// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg: peripheral address map, TCTRL field layout, bus direction
// encoding and the bus address decoder shared by the bus_memory files.
package bus_memory_pkg;

    // Peripheral word addresses
    localparam logic [15:0] LED_ADDR   = 16'hFF00;
    localparam logic [15:0] TCNT_ADDR  = 16'hFF01;
    localparam logic [15:0] TCMP_ADDR  = 16'hFF02;
    localparam logic [15:0] TCTRL_ADDR = 16'hFF03;
    localparam logic [15:0] TSTAT_ADDR = 16'hFF04;

    // TCTRL / TSTAT layout
    localparam int TCTRL_EN_BIT     = 0;
    localparam int TCTRL_IRQ_EN_BIT = 1;
    localparam int TCTRL_PS_LSB     = 4;
    localparam int TCTRL_PS_W       = 4;
    localparam int TSTAT_MATCH_BIT  = 0;

    // rw encoding
    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TCTRL,
        SEL_TSTAT
    } bus_sel_e;

    // Map a bus word address to a target; in_ram is precomputed by the caller
    // because the RAM window depends on the RAM address width.
    function automatic bus_sel_e bus_decode(input logic [15:0] addr, input logic in_ram);
        bus_sel_e sel;
        sel = SEL_NONE;
        if (in_ram) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                LED_ADDR:   sel = SEL_LED;
                TCNT_ADDR:  sel = SEL_TCNT;
                TCMP_ADDR:  sel = SEL_TCMP;
                TCTRL_ADDR: sel = SEL_TCTRL;
                TSTAT_ADDR: sel = SEL_TSTAT;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_memory_if.sv
// bus_memory_if: CPU-side memory bus (direction, word address, write data,
// registered read data). The CPU is the master, bus_memory the slave.
interface bus_memory_if #(
    parameter int DW = 16
);
    logic          rw;
    logic [15:0]   addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output rw, output addr, output wdata, input rdata);
    modport slave  (input rw, input addr, input wdata, output rdata);
endinterface

// File: rtl/bus_memory_mem_timer.sv
// mem_timer: prescaled timer with compare match and sticky match flag.
// Only instantiated when MEM_TIMER_EN is defined.
module mem_timer
    import bus_memory_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_tcnt_i,
    input  logic          we_tcmp_i,
    input  logic          we_tctrl_i,
    input  logic          we_tstat_i,
    output logic [DW-1:0] tcnt_o,
    output logic [DW-1:0] tcmp_o,
    output logic [DW-1:0] tctrl_o,
    output logic [DW-1:0] tstat_o,
    output logic          irq_o
);

    logic [TCTRL_PS_W-1:0] pc_q, pc_d, ps_q, ps_d;
    logic                  en_q, en_d, irq_en_q, irq_en_d;
    logic                  match_q, match_d, irq_q;
    logic [DW-1:0]         tcnt_q, tcnt_d, tcmp_q, tcmp_d;
    logic                  tick;
    logic                  at_cmp;

    // Next-state for prescaler, counter, compare, control and match flag
    always_comb begin
        tick     = en_q && (pc_q == ps_q);
        at_cmp   = (tcnt_q == tcmp_q);

        en_d     = en_q;
        irq_en_d = irq_en_q;
        ps_d     = ps_q;
        if (we_tctrl_i) begin
            en_d     = wdata_i[TCTRL_EN_BIT];
            irq_en_d = wdata_i[TCTRL_IRQ_EN_BIT];
            ps_d     = wdata_i[TCTRL_PS_LSB +: TCTRL_PS_W];
        end

        // A TCTRL write restarts the prescale period
        pc_d = pc_q;
        if (we_tctrl_i || tick) begin
            pc_d = '0;
        end else if (en_q) begin
            pc_d = pc_q + TCTRL_PS_W'(1);
        end

        tcmp_d = we_tcmp_i ? wdata_i : tcmp_q;

        // Bus load of TCNT overrides the tick and suppresses its match
        tcnt_d = tcnt_q;
        if (we_tcnt_i) begin
            tcnt_d = wdata_i;
        end else if (tick) begin
            tcnt_d = at_cmp ? '0 : tcnt_q + DW'(1);
        end

        // Setting the flag takes precedence over a coincident clear
        match_d = match_q;
        if (we_tstat_i && wdata_i[TSTAT_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        if (tick && !we_tcnt_i && at_cmp) begin
            match_d = 1'b1;
        end
    end

    // Timer state registers; irq is registered from the next-state values so
    // it tracks match & irq_en without a combinational path from the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            ps_q     <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            match_q  <= 1'b0;
            irq_q    <= 1'b0;
            tcnt_q   <= '0;
            tcmp_q   <= '1;
        end else begin
            pc_q     <= pc_d;
            ps_q     <= ps_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            match_q  <= match_d;
            irq_q    <= match_d & irq_en_d;
            tcnt_q   <= tcnt_d;
            tcmp_q   <= tcmp_d;
        end
    end

    // Register read views; undefined TCTRL/TSTAT bits read 0
    always_comb begin
        tctrl_o                               = '0;
        tctrl_o[TCTRL_EN_BIT]                 = en_q;
        tctrl_o[TCTRL_IRQ_EN_BIT]             = irq_en_q;
        tctrl_o[TCTRL_PS_LSB +: TCTRL_PS_W]   = ps_q;
        tstat_o                               = '0;
        tstat_o[TSTAT_MATCH_BIT]              = match_q;
    end

    assign tcnt_o = tcnt_q;
    assign tcmp_o = tcmp_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/bus_memory.sv
// bus_memory: word-addressed RAM, LED register and optional timer on the CPU
// bus, with a side-band program-load port. Define MEM_TIMER_EN to include the
// timer at 0xFF01..0xFF04; otherwise those addresses are unmapped and irq is 0.
module bus_memory
    import bus_memory_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_memory_if.slave   bus,
    output logic [DW-1:0] led,
    output logic          irq,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] led_q, led_d, rdata_q, rdata_d;
    logic [DW-1:0] tcnt_v, tcmp_v, tctrl_v, tstat_v;
    logic          timer_irq;
    logic          in_ram, wr;
    bus_sel_e      sel;

    assign in_ram = (bus.addr[15:AW] == '0);
    assign sel    = bus_decode(bus.addr, in_ram);
    assign wr     = (bus.rw == BUS_WR);

    // RAM write port: program load wins over a same-cycle bus RAM write
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (wr && sel == SEL_RAM) begin
            mem[bus.addr[AW-1:0]] <= bus.wdata;
        end
    end

    // LED register next state
    always_comb begin
        led_d = led_q;
        if (wr && sel == SEL_LED) begin
            led_d = bus.wdata;
        end
    end

`ifdef MEM_TIMER_EN
    mem_timer #(
        .DW(DW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wdata_i    (bus.wdata),
        .we_tcnt_i  (wr && sel == SEL_TCNT),
        .we_tcmp_i  (wr && sel == SEL_TCMP),
        .we_tctrl_i (wr && sel == SEL_TCTRL),
        .we_tstat_i (wr && sel == SEL_TSTAT),
        .tcnt_o     (tcnt_v),
        .tcmp_o     (tcmp_v),
        .tctrl_o    (tctrl_v),
        .tstat_o    (tstat_v),
        .irq_o      (timer_irq)
    );
`else
    assign tcnt_v    = '0;
    assign tcmp_v    = '0;
    assign tctrl_v   = '0;
    assign tstat_v   = '0;
    assign timer_irq = 1'b0;
`endif

    // Read mux; sampled before this edge's writes, giving read-first behaviour
    always_comb begin
        rdata_d = '0;
        case (sel)
            SEL_RAM:   rdata_d = mem[bus.addr[AW-1:0]];
            SEL_LED:   rdata_d = led_q;
            SEL_TCNT:  rdata_d = tcnt_v;
            SEL_TCMP:  rdata_d = tcmp_v;
            SEL_TCTRL: rdata_d = tctrl_v;
            SEL_TSTAT: rdata_d = tstat_v;
            default:   rdata_d = '0;
        endcase
    end

    // Registered read data and LED output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            led_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign led       = led_q;
    assign irq       = timer_irq;

endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: directed and randomized checks of bus_memory against a
// word-array reference model of RAM and LED plus closed-form timer timing.
module tb_bus_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led;
    logic        irq;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] load_data = '0;

    int assertions = 0;
    int failures   = 0;

    logic [15:0] m_mem [256];
    logic [15:0] m_led;
    logic [15:0] prog [4];

    bus_memory_if #(.DW(16)) bus ();

    bus_memory #(.AW(8), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .irq       (irq),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    // Drive one bus cycle, return 1ns after the committing edge
    task automatic bus_cycle(input logic rw, input logic [15:0] a, input logic [15:0] d,
                             input logic le, input logic [7:0] la, input logic [15:0] ld);
        bus.rw    = rw;
        bus.addr  = a;
        bus.wdata = d;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_cycle(1'b1, a, d, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic rd(input logic [15:0] a);
        bus_cycle(1'b0, a, 16'h0000, 1'b0, 8'h00, 16'h0000);
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a < 16'h0100) return m_mem[a[7:0]];
        if (a == 16'hFF00) return m_led;
        return 16'h0000;
    endfunction

    task automatic test_reset();
        bus.rw = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got %h want 0000", bus.rdata); end
        assertions++;
        if (led !== 16'h0000) begin failures++; $display("FAIL reset_led got %h want 0000", led); end
        assertions++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
        $display("txn reset checked");
    endtask

    task automatic test_load_fetch();
        logic [15:0] v;
        prog[0] = 16'hA202; prog[1] = 16'h0348; prog[2] = 16'h7000; prog[3] = 16'hB000;
        for (int i = 0; i < 256; i++) begin
            v = (i < 4) ? prog[i] : 16'($urandom);
            bus_cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 8'(i), v);
            m_mem[i] = v;
        end
        rd(16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(16'(i));
            assertions++;
            if (bus.rdata !== prog[i]) begin
                failures++; $display("FAIL fetch addr %0d got %h want %h", i, bus.rdata, prog[i]);
            end
            $display("txn fetch addr %0d rdata %h", i, bus.rdata);
        end
    endtask

    task automatic test_cpu_rw();
        wr(16'h0010, 16'h0F0F); m_mem[16] = 16'h0F0F;
        rd(16'h0010);
        assertions++;
        if (bus.rdata !== 16'h0F0F) begin failures++; $display("FAIL cpu_rd got %h want 0f0f", bus.rdata); end
        wr(16'h0010, 16'h1234);
        assertions++;
        if (bus.rdata !== 16'h0F0F) begin failures++; $display("FAIL read_first got %h want 0f0f", bus.rdata); end
        m_mem[16] = 16'h1234;
        rd(16'h0010);
        assertions++;
        if (bus.rdata !== 16'h1234) begin failures++; $display("FAIL after_wr got %h want 1234", bus.rdata); end
        rd(16'h0100);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL unmapped_0100 got %h want 0000", bus.rdata); end
        $display("txn cpu_rw checked");
    endtask

    task automatic test_load_priority();
        bus_cycle(1'b1, 16'h0005, 16'h2222, 1'b1, 8'h05, 16'h1111); m_mem[5] = 16'h1111;
        rd(16'h0005);
        assertions++;
        if (bus.rdata !== 16'h1111) begin failures++; $display("FAIL load_prio got %h want 1111", bus.rdata); end
        bus_cycle(1'b1, 16'hFF00, 16'h00AA, 1'b1, 8'h06, 16'h3333); m_mem[6] = 16'h3333; m_led = 16'h00AA;
        assertions++;
        if (led !== 16'h00AA) begin failures++; $display("FAIL led_with_load got %h want 00aa", led); end
        rd(16'h0006);
        assertions++;
        if (bus.rdata !== 16'h3333) begin failures++; $display("FAIL load_with_led got %h want 3333", bus.rdata); end
        $display("txn load_priority checked");
    endtask

    task automatic test_random();
        int op;
        logic [15:0] a, d, exp;
        logic rw, le;
        logic [7:0] la;
        for (int t = 0; t < 150; t++) begin
            op = $urandom_range(0, 5);
            rw = 1'b0; le = 1'b0; la = 8'h00; d = 16'($urandom); a = 16'h0000;
            case (op)
                0: begin rw = 1'b1; a = 16'($urandom_range(16, 255)); end
                1: a = 16'($urandom_range(0, 255));
                2: begin rw = 1'b1; a = 16'hFF00; end
                3: a = 16'hFF00;
                4: begin
                    rw = 1'($urandom_range(0, 1));
                    a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0100, 16'hFEFF))
                                                     : 16'($urandom_range(16'hFF05, 16'hFFFF));
                end
                default: begin rw = 1'b1; le = 1'b1; la = 8'($urandom_range(16, 255)); a = 16'($urandom_range(16, 255)); end
            endcase
            exp = m_read(a);
            bus_cycle(rw, a, d, le, la, 16'(~d));
            if (le) m_mem[la] = 16'(~d);
            else if (rw && a < 16'h0100) m_mem[a[7:0]] = d;
            if (rw && a == 16'hFF00) m_led = d;
            assertions++;
            if (bus.rdata !== exp) begin
                failures++; $display("FAIL rand_rdata txn %0d addr %h got %h want %h", t, a, bus.rdata, exp);
            end
            assertions++;
            if (led !== m_led) begin
                failures++; $display("FAIL rand_led txn %0d got %h want %h", t, led, m_led);
            end
            $display("txn %0d op %0d rw %0d addr %h load %0d rdata %h", t, op, rw, a, le, bus.rdata);
        end
        rd(16'h0000);
    endtask

`ifdef MEM_TIMER_EN
    task automatic test_timer_match();
        int k;
        logic [15:0] exp;
        wr(16'hFF03, 16'h0000); wr(16'hFF04, 16'h0001); wr(16'hFF01, 16'h0000); wr(16'hFF02, 16'h0003);
        rd(16'hFF02);
        assertions++;
        if (bus.rdata !== 16'h0003) begin failures++; $display("FAIL tcmp_rd got %h want 0003", bus.rdata); end
        wr(16'hFF03, 16'h0033);
        for (int n = 1; n <= 17; n++) begin
            rd(16'hFF01);
            k = n - 1;
            exp = (k < 16) ? 16'(k / 4) : 16'h0000;
            assertions++;
            if (bus.rdata !== exp) begin failures++; $display("FAIL tcnt cycle %0d got %h want %h", n, bus.rdata, exp); end
            assertions++;
            if (irq !== (n >= 16)) begin failures++; $display("FAIL irq cycle %0d got %b want %b", n, irq, (n >= 16)); end
            $display("txn timer cycle %0d tcnt %h irq %b", n, bus.rdata, irq);
        end
        rd(16'hFF04);
        assertions++;
        if (bus.rdata !== 16'h0001) begin failures++; $display("FAIL tstat_set got %h want 0001", bus.rdata); end
        rd(16'hFF03);
        assertions++;
        if (bus.rdata !== 16'h0033) begin failures++; $display("FAIL tctrl_rd got %h want 0033", bus.rdata); end
        wr(16'hFF04, 16'h0001);
        assertions++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got %b want 0", irq); end
        rd(16'hFF04);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL tstat_clear got %h want 0000", bus.rdata); end
        wr(16'hFF03, 16'h0000);
    endtask

    task automatic test_collision();
        wr(16'hFF03, 16'h0000); wr(16'hFF04, 16'h0001); wr(16'hFF02, 16'h0005); wr(16'hFF01, 16'h0005);
        wr(16'hFF03, 16'h0011);
        rd(16'h0000);
        wr(16'hFF01, 16'h0050);
        rd(16'hFF04);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL tcnt_wr_no_match got %h want 0000", bus.rdata); end
        rd(16'hFF01);
        assertions++;
        if (bus.rdata !== 16'h0050) begin failures++; $display("FAIL tcnt_wr_wins got %h want 0050", bus.rdata); end
        wr(16'hFF03, 16'h0000); wr(16'hFF04, 16'h0001); wr(16'hFF02, 16'h0005); wr(16'hFF01, 16'h0005);
        wr(16'hFF03, 16'h0001);
        wr(16'hFF04, 16'h0001);
        rd(16'hFF04);
        assertions++;
        if (bus.rdata !== 16'h0001) begin failures++; $display("FAIL set_beats_clear got %h want 0001", bus.rdata); end
        wr(16'hFF03, 16'h0000); wr(16'hFF04, 16'h0001);
        $display("txn collision checked");
    endtask
`else
    task automatic test_no_timer();
        wr(16'hFF01, 16'h1234);
        rd(16'hFF01);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL tcnt_unmapped got %h want 0000", bus.rdata); end
        wr(16'hFF02, 16'h0000); wr(16'hFF01, 16'h0000); wr(16'hFF03, 16'h0003);
        for (int n = 0; n < 10; n++) begin
            rd(16'(16'hFF01 + n % 4));
            assertions++;
            if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL timer_unmapped cycle %0d got %h want 0000", n, bus.rdata); end
            assertions++;
            if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied cycle %0d got %b want 0", n, irq); end
            $display("txn no_timer cycle %0d rdata %h irq %b", n, bus.rdata, irq);
        end
    endtask
`endif

    task automatic test_reset_midrun();
`ifdef MEM_TIMER_EN
        wr(16'hFF03, 16'h0000); wr(16'hFF04, 16'h0001); wr(16'hFF02, 16'h0000); wr(16'hFF01, 16'h0000);
        wr(16'hFF03, 16'h0003);
`endif
        wr(16'hFF00, 16'hFFFF);
        rd(16'hFF00); rd(16'hFF00); rd(16'hFF00);
        assertions++;
        if (bus.rdata !== 16'hFFFF) begin failures++; $display("FAIL pre_reset_rdata got %h want ffff", bus.rdata); end
`ifdef MEM_TIMER_EN
        assertions++;
        if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got %b want 1", irq); end
`endif
        #2;
        rst = 1'b1;
        #1;
        assertions++;
        if (led !== 16'h0000) begin failures++; $display("FAIL async_led got %h want 0000", led); end
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL async_rdata got %h want 0000", bus.rdata); end
        assertions++;
        if (irq !== 1'b0) begin failures++; $display("FAIL async_irq got %b want 0", irq); end
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef MEM_TIMER_EN
        rd(16'hFF02);
        assertions++;
        if (bus.rdata !== 16'hFFFF) begin failures++; $display("FAIL reset_tcmp got %h want ffff", bus.rdata); end
        rd(16'hFF01);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL reset_tcnt got %h want 0000", bus.rdata); end
        rd(16'hFF03);
        assertions++;
        if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL reset_tctrl got %h want 0000", bus.rdata); end
`endif
        for (int i = 0; i < 4; i++) begin
            rd(16'(i));
            assertions++;
            if (bus.rdata !== prog[i]) begin failures++; $display("FAIL ram_kept addr %0d got %h want %h", i, bus.rdata, prog[i]); end
        end
        $display("txn reset_midrun checked");
    endtask

    initial begin
        m_led = 16'h0000;
        test_reset();
        test_load_fetch();
        test_cpu_rw();
        test_load_priority();
        test_random();
`ifdef MEM_TIMER_EN
        test_timer_match();
        test_collision();
`else
        test_no_timer();
`endif
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
